// File: rtl/fifo_serial_tx.sv
// Drains a synchronous FIFO and serialises each word as start, data LSB-first, [parity], stop.
// Optional even-parity bit is enabled by defining FIFO_SERIAL_TX_PARITY_EN.
module fifo_serial_tx #(
  parameter int MEMORY_WIDTH = 4,
  parameter int BIT_CYCLES   = 2,
  parameter int CNT_SIZE     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fifo_empty,
  input  logic [MEMORY_WIDTH-1:0] fifo_rd,
  output logic                    fifo_r_en,
  input  logic                    tx_ready,
  output logic                    sdo,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int BIT_W = $clog2(MEMORY_WIDTH + 1);
  localparam logic [CNT_SIZE-1:0] PER_LAST = CNT_SIZE'(BIT_CYCLES - 1);
  localparam logic [BIT_W-1:0]    BIT_LAST = BIT_W'(MEMORY_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
`ifdef FIFO_SERIAL_TX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [MEMORY_WIDTH-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [CNT_SIZE-1:0]     per_cnt_q, per_cnt_d;
  logic                    per_last;
`ifdef FIFO_SERIAL_TX_PARITY_EN
  logic                    parity_q, parity_d;
`endif

  assign per_last = (per_cnt_q == PER_LAST);
  assign busy     = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      per_cnt_q <= '0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      per_cnt_q <= per_cnt_d;
`ifdef FIFO_SERIAL_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // sdo is decoded from state so an asynchronous reset forces the line idle at once
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    per_cnt_d  = per_cnt_q;
`ifdef FIFO_SERIAL_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    fifo_r_en  = 1'b0;
    sdo        = 1'b1;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        per_cnt_d = '0;
        bit_cnt_d = '0;
        fifo_r_en = rst && !fifo_empty && tx_ready;
        if (fifo_r_en) state_d = LOAD;
      end
      LOAD: begin
        shift_d   = fifo_rd;
`ifdef FIFO_SERIAL_TX_PARITY_EN
        parity_d  = ^fifo_rd;
`endif
        per_cnt_d = '0;
        bit_cnt_d = '0;
        state_d   = START;
      end
      START: begin
        sdo = 1'b0;
        if (per_last) begin
          per_cnt_d = '0;
          state_d   = DATA;
        end else begin
          per_cnt_d = per_cnt_q + CNT_SIZE'(1);
        end
      end
      DATA: begin
        sdo = shift_q[0];
        if (per_last) begin
          per_cnt_d = '0;
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == BIT_LAST) begin
`ifdef FIFO_SERIAL_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          per_cnt_d = per_cnt_q + CNT_SIZE'(1);
        end
      end
`ifdef FIFO_SERIAL_TX_PARITY_EN
      PARITY: begin
        sdo = parity_q;
        if (per_last) begin
          per_cnt_d = '0;
          state_d   = STOP;
        end else begin
          per_cnt_d = per_cnt_q + CNT_SIZE'(1);
        end
      end
`endif
      STOP: begin
        sdo = 1'b1;
        if (per_last) begin
          frame_done = 1'b1;
          per_cnt_d  = '0;
          state_d    = IDLE;
        end else begin
          per_cnt_d = per_cnt_q + CNT_SIZE'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: a queue-style FIFO model feeds the DUT and each frame is compared
// against a bit-level frame built from the word (start, LSB-first data, optional parity, stop).
module tb_fifo_serial_tx;

  localparam int MW = 4;
  localparam int BC = 2;
`ifdef FIFO_SERIAL_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL = (MW + 2 + PAR) * BC;

  logic          clk;
  logic          rst;
  logic          fifo_empty;
  logic [MW-1:0] fifo_rd;
  logic          fifo_r_en;
  logic          tx_ready;
  logic          sdo;
  logic          busy;
  logic          frame_done;

  int checks = 0;
  int fails  = 0;

  logic [MW-1:0] mem [0:255];
  int push_cnt = 0;
  int pop_cnt  = 0;

  assign fifo_empty = (push_cnt == pop_cnt);

  fifo_serial_tx #(
    .MEMORY_WIDTH(MW),
    .BIT_CYCLES  (BC),
    .CNT_SIZE    (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_rd   (fifo_rd),
    .fifo_r_en (fifo_r_en),
    .tx_ready  (tx_ready),
    .sdo       (sdo),
    .busy      (busy),
    .frame_done(frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // FIFO read port: RD is registered and valid the cycle after an accepted r_en
  always @(posedge clk) begin
    if (fifo_r_en) begin
      fifo_rd <= mem[pop_cnt[7:0]];
      pop_cnt <= pop_cnt + 1;
    end
  end

  task automatic push(input logic [MW-1:0] w);
    mem[push_cnt[7:0]] = w;
    push_cnt = push_cnt + 1;
    #1;
  endtask

  function automatic logic [63:0] exp_frame(input logic [MW-1:0] w);
    logic [63:0] v;
    int b;
    v = '0;
    for (int k = 0; k < FL; k++) begin
      b = k / BC;
      if (b == 0) v[k] = 1'b0;
      else if (b <= MW) v[k] = w[b-1];
      else if (PAR == 1 && b == MW + 1) v[k] = (($countones(w) % 2) == 1);
      else v[k] = 1'b1;
    end
    return v;
  endfunction

  // Waits for a pop, then checks LOAD, the whole frame and the IDLE cycle after it.
  task automatic check_frame(input logic [MW-1:0] w, input int drop_at, input string tag,
                             output int waited);
    int t, p0, nbusy, nfd, fdpos, nren;
    logic [63:0] obs, ex;
    t = 0;
    waited = 0;
    while (fifo_r_en !== 1'b1 && t < 64) begin
      @(negedge clk);
      t++;
    end
    waited = t;
    checks++;
    if (fifo_r_en !== 1'b1) begin
      fails++;
      $display("FAIL %s pop_timeout: fifo_r_en=%b after %0d cycles, required 1", tag, fifo_r_en, t);
      return;
    end
    p0 = pop_cnt;
    @(negedge clk);
    checks++;
    if ({sdo, busy, fifo_r_en} !== 3'b110 || pop_cnt != p0 + 1) begin
      fails++;
      $display("FAIL %s load: sdo/busy/r_en=%b pops=%0d, required 110 pops=%0d",
               tag, {sdo, busy, fifo_r_en}, pop_cnt - p0, 1);
    end
    obs = '0; nbusy = 0; nfd = 0; fdpos = -1; nren = 0;
    for (int k = 0; k < FL; k++) begin
      @(negedge clk);
      if (k == drop_at) tx_ready = 1'b0;
      obs[k] = sdo;
      if (busy === 1'b1) nbusy++;
      if (frame_done === 1'b1) begin nfd++; fdpos = k; end
      if (fifo_r_en !== 1'b0) nren++;
    end
    ex = exp_frame(w);
    checks++;
    if (obs !== ex) begin
      fails++;
      $display("FAIL %s sdo_frame: word=%h got %h, required %h", tag, w, obs, ex);
    end
    checks++;
    if (nfd != 1 || fdpos != FL - 1) begin
      fails++;
      $display("FAIL %s frame_done: count=%0d pos=%0d, required count=1 pos=%0d", tag, nfd, fdpos, FL - 1);
    end
    checks++;
    if (nbusy != FL) begin
      fails++;
      $display("FAIL %s busy_len: got %0d, required %0d", tag, nbusy, FL);
    end
    checks++;
    if (nren != 0) begin
      fails++;
      $display("FAIL %s pop_in_frame: got %0d, required 0", tag, nren);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || sdo !== 1'b1) begin
      fails++;
      $display("FAIL %s idle_after: busy=%b sdo=%b, required busy=0 sdo=1", tag, busy, sdo);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tx_ready = 1'b1;
    push(4'h5);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({fifo_r_en, sdo, busy, frame_done} !== 4'b0100) begin
        fails++;
        $display("FAIL reset_hold: r_en/sdo/busy/done=%b, required 0100", {fifo_r_en, sdo, busy, frame_done});
      end
    end
    checks++;
    if (pop_cnt != 0) begin
      fails++;
      $display("FAIL reset_no_pop: pops=%0d, required 0", pop_cnt);
    end
    push_cnt = pop_cnt;
    rst = 1'b1;
    #1;
    @(negedge clk);
    checks++;
    if ({fifo_r_en, sdo, busy} !== 3'b010) begin
      fails++;
      $display("FAIL idle_empty: r_en/sdo/busy=%b, required 010", {fifo_r_en, sdo, busy});
    end
  endtask

  task automatic test_single();
    int wt, p0;
    p0 = pop_cnt;
    push(4'hA);
    check_frame(4'hA, -1, "single", wt);
    checks++;
    if (pop_cnt != p0 + 1) begin
      fails++;
      $display("FAIL single_pops: got %0d, required 1", pop_cnt - p0);
    end
  endtask

  task automatic test_parity_words();
    int wt;
    push(4'hB);
    push(4'h3);
    check_frame(4'hB, -1, "word_b", wt);
    check_frame(4'h3, -1, "word_3", wt);
  endtask

  task automatic test_back_to_back();
    int wt, p0;
    p0 = pop_cnt;
    push(4'h1);
    push(4'hF);
    check_frame(4'h1, -1, "b2b_first", wt);
    check_frame(4'hF, -1, "b2b_second", wt);
    checks++;
    if (wt + 2 != 2) begin
      fails++;
      $display("FAIL b2b_gap: got %0d idle cycles, required 2", wt + 2);
    end
    checks++;
    if (pop_cnt != p0 + 2) begin
      fails++;
      $display("FAIL b2b_pops: got %0d, required 2", pop_cnt - p0);
    end
  endtask

  task automatic test_flow_control();
    int wt, bad;
    logic [MW-1:0] wa, wb, wc;
    wa = 4'($urandom); wb = 4'($urandom); wc = 4'($urandom);
    tx_ready = 1'b0;
    push(wa);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if ({fifo_r_en, sdo, busy} !== 3'b010) bad++;
    end
    checks++;
    if (bad != 0) begin
      fails++;
      $display("FAIL not_ready_hold: %0d bad cycles, required 0", bad);
    end
    tx_ready = 1'b1;
    #1;
    check_frame(wa, -1, "ready_frame", wt);
    push(wb);
    push(wc);
    check_frame(wb, 3, "drop_mid", wt);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if ({fifo_r_en, sdo, busy} !== 3'b010) bad++;
    end
    checks++;
    if (bad != 0) begin
      fails++;
      $display("FAIL wait_ready: %0d bad cycles, required 0", bad);
    end
    tx_ready = 1'b1;
    #1;
    check_frame(wc, -1, "resume", wt);
  endtask

  task automatic test_reset_mid();
    int wt, p0, t;
    logic [MW-1:0] w1, w2;
    w1 = 4'($urandom) & 4'b1101;
    w2 = 4'($urandom);
    p0 = pop_cnt;
    push(w1);
    push(w2);
    t = 0;
    while (fifo_r_en !== 1'b1 && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (fifo_r_en !== 1'b1) begin
      $display("FAIL rst_mid_pop_timeout: fifo_r_en=%b, required 1", fifo_r_en);
      $fatal(1, "no pop");
    end
    repeat (1 + BC + BC + 1) @(negedge clk);
    checks++;
    if (sdo !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_data1: sdo=%b busy=%b, required sdo=0 busy=1", sdo, busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({sdo, busy, fifo_r_en, frame_done} !== 4'b1000) begin
      fails++;
      $display("FAIL rst_mid_async: sdo/busy/r_en/done=%b, required 1000", {sdo, busy, fifo_r_en, frame_done});
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({sdo, busy, fifo_r_en} !== 3'b100) begin
      fails++;
      $display("FAIL rst_mid_held: sdo/busy/r_en=%b, required 100", {sdo, busy, fifo_r_en});
    end
    rst = 1'b1;
    #1;
    check_frame(w2, -1, "after_rst", wt);
    checks++;
    if (wt != 0 || pop_cnt != p0 + 2) begin
      fails++;
      $display("FAIL rst_mid_pops: wait=%0d pops=%0d, required wait=0 pops=2", wt, pop_cnt - p0);
    end
  endtask

  task automatic test_random();
    int wt;
    logic [MW-1:0] w;
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      w = 4'($urandom);
      push(w);
      check_frame(w, -1, "random", wt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_parity_words();
    test_back_to_back();
    test_flow_control();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
